psum_acc: RTL
=============

# psum_acc

Partial-sum accumulator at the bottom edge of the systolic array: receives the Psum/Addr/Valid stream leaving the last PE row, sign-extends each psum and accumulates it into an on-chip buffer indexed by address. On command it drains the buffer in address order over a valid/ready port, clearing each entry as it leaves, so the next tile starts from zero.

## Interface
Parameters:
- DEPTH, 1 << `BIT_ADDR, number of accumulator entries; addresses >= DEPTH are out of range.
- BIT_ACC, 32, accumulator width; must be >= `BIT_PSUM.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  asynchronous, active-high reset.
- Psum_In  input  `BIT_PSUM  signed psum from last PE row.
- Addr_P_In  input  `BIT_ADDR  accumulator address for Psum_In.
- Valid_P_In  input  `BIT_VALID  psum valid when nonzero.
- Drain_Start  input  1  one-cycle request to drain the buffer.
- Data_O_Out  output  BIT_ACC  signed drained accumulator value.
- Addr_O_Out  output  `BIT_ADDR  address of Data_O_Out.
- Valid_O_Out  output  1  drain beat valid.
- Ready_O_In  input  1  downstream accepts the beat.
- Busy  output  1  high in FLUSH or DRAIN.
- Done  output  1  one-cycle pulse after last drain beat accepted.
- Drop_Err  output  1  sticky: a valid psum arrived while Busy, or Addr_P_In >= DEPTH.
- Ovf  output  1  sticky: an accumulate overflowed BIT_ACC.

## Operation
- State machine ACC, FLUSH, DRAIN. Reset -> ACC.
- ACC: every valid psum enters a 2-stage read-modify-write pipe. S1 registers {psum, addr} and reads entry; S2 writes entry + sext(psum). Back-to-back and every-other-cycle hits on the same address forward the S2 result into S1; no stall, no lost update.
- Per-entry occupancy bit: cleared by reset and by drain; unoccupied entry reads as 0 (RAM contents not reset).
- Drain_Start in ACC -> FLUSH; ignored in FLUSH/DRAIN. A valid psum in the same cycle as Drain_Start is accepted and included.
- FLUSH: 2 cycles, pipe empties -> DRAIN.
- DRAIN: emits addresses 0..DEPTH-1 in order; beat held stable (Data, Addr, Valid) until Valid_O_Out && Ready_O_In; accepted entry's occupancy cleared. After address DEPTH-1 accepted: Done pulses, -> ACC.
- Valid psum during FLUSH/DRAIN: dropped, Drop_Err set. Out-of-range address: dropped, Drop_Err set, any state.
- Arithmetic: psum sign-extended to BIT_ACC; two's-complement wrap; Ovf set when operand signs match and result sign differs.
- Drop_Err, Ovf clear only on RST.
- RST mid-DRAIN: abort immediately, all occupancy cleared, outputs to reset values.

## Timing
- Reset values: Data_O_Out 0, Addr_O_Out 0, Valid_O_Out 0, Busy 0, Done 0, Drop_Err 0, Ovf 0.
- Psum accepted at edge t is visible in the entry (and to drain) from edge t+2.
- Drain_Start at edge t: Busy high after t; first Valid_O_Out after t+3 (2 FLUSH + 1 read).
- Drain throughput 1 beat/cycle with Ready_O_In held high; DEPTH beats in DEPTH cycles. Ready low stalls without reordering.
- Done high the cycle after final handshake; Busy falls same cycle.

## Configuration
- PSUM_ACC_SAT_EN defined: overflowing accumulate clamps to max/min signed BIT_ACC value; Ovf still set.
- Undefined: two's-complement wrap; Ovf set.

## Test plan
- Psums 5 then -3 to addr 2 on consecutive cycles, drain -> beat addr 2 = 2, all others 0, Done after DEPTH beats.
- Same addr 7 gets +1 on 8 consecutive cycles, then drain -> addr 7 = 8 (forwarding check).
- Drain with Ready_O_In toggling 1/0 every cycle -> beats 0..DEPTH-1 in order, each held while stalled, no duplicates; second drain returns all zeros.
- Valid psum during FLUSH and addr >= DEPTH in ACC -> Drop_Err=1, buffer contents unchanged.
- BIT_ACC=16: add 32767 then +1 to addr 0 -> Ovf=1, drained -32768 (wrap) or 32767 with PSUM_ACC_SAT_EN.
- Assert RST mid-drain at beat 3 -> all outputs to reset values; subsequent drain returns zeros.

Source files
------------

// File: rtl/psum_acc.sv
// Partial-sum accumulator below the last PE row: read-modify-write accumulate into a
// per-address buffer, then ordered valid/ready drain. Define PSUM_ACC_SAT_EN for saturation.
`ifndef BIT_PSUM
`define BIT_PSUM 16
`endif
`ifndef BIT_ADDR
`define BIT_ADDR 4
`endif
`ifndef BIT_VALID
`define BIT_VALID 1
`endif

module psum_acc #(
  parameter int DEPTH   = 1 << `BIT_ADDR,
  parameter int BIT_ACC = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [`BIT_PSUM-1:0]  Psum_In,
  input  logic [`BIT_ADDR-1:0]  Addr_P_In,
  input  logic [`BIT_VALID-1:0] Valid_P_In,
  input  logic                  Drain_Start,
  output logic [BIT_ACC-1:0]    Data_O_Out,
  output logic [`BIT_ADDR-1:0]  Addr_O_Out,
  output logic                  Valid_O_Out,
  input  logic                  Ready_O_In,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Drop_Err,
  output logic                  Ovf
);

  typedef enum logic [1:0] {ST_ACC, ST_FLUSH, ST_DRAIN} state_e;

  state_e                      state_q, state_d;
  logic                        flush_cnt_q, flush_cnt_d;
  logic [DEPTH-1:0]            occ_q, occ_d;
  logic [BIT_ACC-1:0]          mem_q [DEPTH];

  logic                        s1_vld_q, s1_vld_d;
  logic [`BIT_PSUM-1:0]        s1_psum_q, s1_psum_d;
  logic [`BIT_ADDR-1:0]        s1_addr_q, s1_addr_d;
  logic [BIT_ACC-1:0]          s1_rd;

  logic                        s2_vld_q, s2_vld_d;
  logic signed [`BIT_PSUM-1:0] s2_psum_q, s2_psum_d;
  logic [`BIT_ADDR-1:0]        s2_addr_q, s2_addr_d;
  logic [BIT_ACC-1:0]          s2_old_q, s2_old_d;
  logic [BIT_ACC-1:0]          psum_ext, sum_raw, s2_res;
  logic                        ovf_now;

  logic [BIT_ACC-1:0]          data_o_q, data_o_d;
  logic [`BIT_ADDR-1:0]        addr_o_q, addr_o_d;
  logic                        valid_o_q, valid_o_d;
  logic                        done_q, done_d;
  logic                        drop_q, drop_d;
  logic                        ovf_q, ovf_d;

  logic                        psum_vld, in_range, accept, hs, last_beat;
  logic [`BIT_ADDR-1:0]        ld_addr;

`ifdef PSUM_ACC_SAT_EN
  localparam logic [BIT_ACC-1:0] SAT_MAX = {1'b0, {(BIT_ACC-1){1'b1}}};
  localparam logic [BIT_ACC-1:0] SAT_MIN = {1'b1, {(BIT_ACC-1){1'b0}}};
`endif

  always_comb begin
    psum_vld  = |Valid_P_In;
    in_range  = int'(Addr_P_In) < DEPTH;
    accept    = psum_vld && in_range && (state_q == ST_ACC);
    hs        = valid_o_q && Ready_O_In;
    last_beat = int'(addr_o_q) == DEPTH - 1;
    ld_addr   = valid_o_q ? addr_o_q + `BIT_ADDR'(1) : '0;
  end

  // S2 arithmetic; its result also forwards into S1 so same-address hits never see stale data
  always_comb begin
    psum_ext = BIT_ACC'(s2_psum_q);
    sum_raw  = s2_old_q + psum_ext;
    ovf_now  = (s2_old_q[BIT_ACC-1] == psum_ext[BIT_ACC-1]) &&
               (sum_raw[BIT_ACC-1] != s2_old_q[BIT_ACC-1]);
`ifdef PSUM_ACC_SAT_EN
    s2_res   = ovf_now ? (s2_old_q[BIT_ACC-1] ? SAT_MIN : SAT_MAX) : sum_raw;
`else
    s2_res   = sum_raw;
`endif
  end

  always_comb begin
    if (s2_vld_q && (s2_addr_q == s1_addr_q)) begin
      s1_rd = s2_res;
    end else if (occ_q[s1_addr_q]) begin
      s1_rd = mem_q[s1_addr_q];
    end else begin
      s1_rd = '0;
    end
  end

  always_comb begin
    s1_vld_d  = accept;
    s1_psum_d = accept ? Psum_In : s1_psum_q;
    s1_addr_d = accept ? Addr_P_In : s1_addr_q;
    s2_vld_d  = s1_vld_q;
    s2_psum_d = s1_psum_q;
    s2_addr_d = s1_addr_q;
    s2_old_d  = s1_rd;
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    data_o_d    = data_o_q;
    addr_o_d    = addr_o_q;
    valid_o_d   = valid_o_q;
    done_d      = 1'b0;
    occ_d       = occ_q;
    drop_d      = drop_q | (psum_vld && (!in_range || (state_q != ST_ACC)));
    ovf_d       = ovf_q | (s2_vld_q && ovf_now);

    if (s2_vld_q) begin
      occ_d[s2_addr_q] = 1'b1;
    end
    if (hs) begin
      occ_d[addr_o_q] = 1'b0;
    end

    case (state_q)
      ST_ACC: begin
        if (Drain_Start) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q) begin
          state_d = ST_DRAIN;
        end else begin
          flush_cnt_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        // next beat is prefetched on the accepting edge so Ready held high gives 1 beat/cycle
        if (hs && last_beat) begin
          valid_o_d = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_ACC;
        end else if (!valid_o_q || hs) begin
          addr_o_d  = ld_addr;
          data_o_d  = occ_q[ld_addr] ? mem_q[ld_addr] : '0;
          valid_o_d = 1'b1;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_ACC;
      flush_cnt_q <= 1'b0;
      occ_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_psum_q   <= '0;
      s1_addr_q   <= '0;
      s2_vld_q    <= 1'b0;
      s2_psum_q   <= '0;
      s2_addr_q   <= '0;
      s2_old_q    <= '0;
      data_o_q    <= '0;
      addr_o_q    <= '0;
      valid_o_q   <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      occ_q       <= occ_d;
      s1_vld_q    <= s1_vld_d;
      s1_psum_q   <= s1_psum_d;
      s1_addr_q   <= s1_addr_d;
      s2_vld_q    <= s2_vld_d;
      s2_psum_q   <= s2_psum_d;
      s2_addr_q   <= s2_addr_d;
      s2_old_q    <= s2_old_d;
      data_o_q    <= data_o_d;
      addr_o_q    <= addr_o_d;
      valid_o_q   <= valid_o_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
    end
  end

  // Buffer storage is not reset; the occupancy bits mask stale contents
  always_ff @(posedge CLK) begin
    if (s2_vld_q) begin
      mem_q[s2_addr_q] <= s2_res;
    end
  end

  always_comb begin
    Data_O_Out  = data_o_q;
    Addr_O_Out  = addr_o_q;
    Valid_O_Out = valid_o_q;
    Busy        = state_q != ST_ACC;
    Done        = done_q;
    Drop_Err    = drop_q;
    Ovf         = ovf_q;
  end

endmodule
